// File: rtl/ipu_pkg.sv
// Shared opcode encoding and row/opcode decode helpers for the IPU pipeline.
package ipu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MLT = 2'b01,
    OP_MV  = 2'b10,
    OP_RD  = 2'b11
  } op_e;

  // MSB bit index of element j in a row of rw bits built from w-bit elements; element 0 sits at the top.
  function automatic int unsigned elem_msb(input int unsigned j, input int unsigned w,
                                           input int unsigned rw);
    return rw - 1 - j * w;
  endfunction

  // Every opcode except RD writes its destination row.
  function automatic logic op_writes(input logic [1:0] op);
    return op != OP_RD;
  endfunction

  // ADD reads a second full row at AB.
  function automatic logic op_reads_b(input logic [1:0] op);
    return op == OP_ADD;
  endfunction

  // MLT reads the block of N rows starting at AB.
  function automatic logic op_reads_blk(input logic [1:0] op);
    return op == OP_MLT;
  endfunction

endpackage

// File: rtl/ipu_lane.sv
// One element lane: add, column multiply-accumulate or pass-through, with overflow detect and wrap/saturate.
module ipu_lane
  import ipu_pkg::*;
#(
  parameter int unsigned W   = 4,
  parameter int unsigned N   = 4,
  parameter int unsigned SAT = 0
) (
  input  logic [1:0]     i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic [N*W-1:0] i_avec,
  input  logic [N*W-1:0] i_col,
  output logic [W-1:0]   o_res,
  output logic           o_of
);

  localparam int unsigned RW = N * W;
  localparam int unsigned PW = 2 * W + $clog2(N) + 1;
  localparam logic [PW-1:0] MAXV = PW'({W{1'b1}});

  logic [PW-1:0] w_acc [N+1];
  logic [PW-1:0] w_sum;

  assign w_acc[0] = '0;

  // Dot product of row A with this lane's column of the B block.
  for (genvar k = 0; k < N; k++) begin : g_mac
    assign w_acc[k+1] = w_acc[k] + PW'(i_avec[elem_msb(k, W, RW) -: W]) * PW'(i_col[elem_msb(k, W, RW) -: W]);
  end

  // Full-precision result for the selected operation.
  always_comb begin
    w_sum = '0;
    case (i_op)
      OP_ADD:  w_sum = PW'(i_a) + PW'(i_b);
      OP_MLT:  w_sum = w_acc[N];
      default: w_sum = PW'(i_a);
    endcase
  end

  assign o_of  = (w_sum > MAXV);
  assign o_res = (o_of && (SAT != 0)) ? W'(MAXV) : w_sum[W-1:0];

endmodule

// File: rtl/ipu_pipe.sv
// Three-stage row-vector pipeline (accept, operand fetch, execute, commit) over a host-loadable register file.
module ipu_pipe
  import ipu_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SAT   = 0,
  localparam int unsigned RW   = N * W,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          top_clk,
  input  logic          top_rst,
  input  logic          top_ld_en,
  input  logic [AW-1:0] top_ld_adrs,
  input  logic [RW-1:0] top_ld_data,
  input  logic          top_in_valid,
  output logic          top_in_ready,
  input  logic [1:0]    top_in_op,
  input  logic [AW-1:0] top_in_DA,
  input  logic [AW-1:0] top_in_AA,
  input  logic [AW-1:0] top_in_AB,
  output logic          top_out_valid,
  output logic [RW-1:0] top_out_data,
  output logic [AW-1:0] top_out_adrs,
  output logic          top_OF,
  output logic [15:0]   top_retired
);

  logic [RW-1:0] r_rf [DEPTH];

  logic          r_s1_valid, r_s2_valid, r_s3_valid;
  logic [1:0]    r_s1_op, r_s2_op, r_s3_op;
  logic [AW-1:0] r_s1_da, r_s1_aa, r_s1_ab;
  logic [AW-1:0] r_s2_da, r_s2_aa, r_s3_da, r_s3_aa;
  logic [RW-1:0] r_s2_a;
  logic [N-1:0][RW-1:0] r_s2_rows;
  logic [RW-1:0] r_s3_res;
  logic          r_s3_of;

  logic                 w_hazard, w_accept, w_commit_we;
  logic [N-1:0][AW-1:0] w_row_adr;
  logic [N-1:0][RW-1:0] w_rows;
  logic [N-1:0][RW-1:0] w_col;
  logic [RW-1:0]        w_res;
  logic [N-1:0]         w_of;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int unsigned k);
    return AW'((32'(base) + k) % DEPTH);
  endfunction

  // True when a pending write to da would be read by the offered instruction.
  function automatic logic src_hit(input logic [AW-1:0] da, input logic [1:0] op,
                                   input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    logic hit;
    hit = (da == aa);
    if (op_reads_b(op) && (da == ab)) hit = 1'b1;
    if (op_reads_blk(op) && (((32'(da) + DEPTH - 32'(ab)) % DEPTH) < N)) hit = 1'b1;
    return hit;
  endfunction

  // Stall on writers in fetch/execute; a writer at commit lands before the new instruction fetches.
  always_comb begin
    w_hazard = 1'b0;
    if (r_s1_valid && op_writes(r_s1_op) && src_hit(r_s1_da, top_in_op, top_in_AA, top_in_AB))
      w_hazard = 1'b1;
    if (r_s2_valid && op_writes(r_s2_op) && src_hit(r_s2_da, top_in_op, top_in_AA, top_in_AB))
      w_hazard = 1'b1;
  end

  assign top_in_ready = !top_rst && !top_ld_en && !w_hazard;
  assign w_accept     = top_in_valid && top_in_ready;

  // Row fetch addresses for the B block and per-lane column gather.
  for (genvar k = 0; k < N; k++) begin : g_rows
    assign w_row_adr[k] = wrap_add(r_s1_ab, k);
    assign w_rows[k]    = r_rf[w_row_adr[k]];
    for (genvar j = 0; j < N; j++) begin : g_col
      assign w_col[j][elem_msb(k, W, RW) -: W] = r_s2_rows[k][elem_msb(j, W, RW) -: W];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_lane
    ipu_lane #(.W(W), .N(N), .SAT(SAT)) u_lane (
      .i_op   (r_s2_op),
      .i_a    (r_s2_a[elem_msb(j, W, RW) -: W]),
      .i_b    (r_s2_rows[0][elem_msb(j, W, RW) -: W]),
      .i_avec (r_s2_a),
      .i_col  (w_col[j]),
      .o_res  (w_res[elem_msb(j, W, RW) -: W]),
      .o_of   (w_of[j])
    );
  end

  // Stage valid bits; reset drops everything in flight.
  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Stage payloads advance every cycle and are qualified by the valid bits.
  always_ff @(posedge top_clk) begin
    r_s1_op   <= top_in_op;
    r_s1_da   <= top_in_DA;
    r_s1_aa   <= top_in_AA;
    r_s1_ab   <= top_in_AB;
    r_s2_op   <= r_s1_op;
    r_s2_da   <= r_s1_da;
    r_s2_aa   <= r_s1_aa;
    r_s2_a    <= r_rf[r_s1_aa];
    r_s2_rows <= w_rows;
    r_s3_op   <= r_s2_op;
    r_s3_da   <= r_s2_da;
    r_s3_aa   <= r_s2_aa;
    r_s3_res  <= w_res;
    r_s3_of   <= |w_of;
  end

  assign w_commit_we = r_s3_valid && !top_rst && op_writes(r_s3_op);

  // Register file: host load and commit share the edge; the commit write is last so it wins.
  always_ff @(posedge top_clk) begin
    if (top_ld_en) r_rf[top_ld_adrs] <= top_ld_data;
    if (w_commit_we) r_rf[r_s3_da] <= r_s3_res;
  end

  // Commit-side outputs: RD strobe, sticky overflow, retire counter.
  always_ff @(posedge top_clk) begin
    if (top_rst) begin
      top_out_valid <= 1'b0;
      top_out_data  <= '0;
      top_out_adrs  <= '0;
      top_OF        <= 1'b0;
      top_retired   <= '0;
    end else begin
      top_out_valid <= 1'b0;
      if (r_s3_valid) begin
        top_retired <= top_retired + 16'd1;
        if (r_s3_of) top_OF <= 1'b1;
        if (r_s3_op == OP_RD) begin
          top_out_valid <= 1'b1;
          top_out_data  <= r_s3_res;
          top_out_adrs  <= r_s3_aa;
        end
      end
    end
  end

endmodule

// File: tb/tb_ipu_pipe.sv
// Self-checking bench: wrap and saturate instances driven in lockstep against a program-order row model.
module tb_ipu_pipe;

  localparam int unsigned W = 4, N = 4, DEPTH = 16, RW = 16;
  localparam int MAXE = (1 << W) - 1;
  localparam bit [1:0] OPADD = 2'd0, OPMLT = 2'd1, OPMV = 2'd2, OPRD = 2'd3;

  logic        clk = 1'b0;
  logic        rst, ld_en, in_valid;
  logic [3:0]  ld_adrs, in_da, in_aa, in_ab;
  logic [15:0] ld_data;
  logic [1:0]  in_op;

  logic        rdy [2];
  logic        ov  [2];
  logic [15:0] od  [2];
  logic [3:0]  oa  [2];
  logic        oof [2];
  logic [15:0] ret [2];

  ipu_pipe #(.W(4), .N(4), .DEPTH(16), .SAT(0)) u_dut0 (
    .top_clk(clk), .top_rst(rst), .top_ld_en(ld_en), .top_ld_adrs(ld_adrs), .top_ld_data(ld_data),
    .top_in_valid(in_valid), .top_in_ready(rdy[0]), .top_in_op(in_op),
    .top_in_DA(in_da), .top_in_AA(in_aa), .top_in_AB(in_ab),
    .top_out_valid(ov[0]), .top_out_data(od[0]), .top_out_adrs(oa[0]),
    .top_OF(oof[0]), .top_retired(ret[0])
  );

  ipu_pipe #(.W(4), .N(4), .DEPTH(16), .SAT(1)) u_dut1 (
    .top_clk(clk), .top_rst(rst), .top_ld_en(ld_en), .top_ld_adrs(ld_adrs), .top_ld_data(ld_data),
    .top_in_valid(in_valid), .top_in_ready(rdy[1]), .top_in_op(in_op),
    .top_in_DA(in_da), .top_in_AA(in_aa), .top_in_AB(in_ab),
    .top_out_valid(ov[1]), .top_out_data(od[1]), .top_out_adrs(oa[1]),
    .top_OF(oof[1]), .top_retired(ret[1])
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: index 0 = wrap instance, 1 = saturating instance.
  bit [15:0] mrf [2][16];
  bit        mof [2];
  int        mret;

  typedef struct {
    int        due;
    bit [3:0]  adrs;
    bit [15:0] d0;
    bit [15:0] d1;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int el(input bit [15:0] row, input int j);
    bit [15:0] t;
    t = row >> (RW - W * (j + 1));
    return int'(t & 16'(MAXE));
  endfunction

  // Row result from the arithmetic definition of each opcode.
  function automatic bit [15:0] m_calc(input int s, input bit [1:0] op, input int aa, input int ab,
                                       output bit ovf);
    bit [15:0] r;
    int v;
    r = '0;
    ovf = 1'b0;
    for (int j = 0; j < N; j++) begin
      case (op)
        OPADD: v = el(mrf[s][aa], j) + el(mrf[s][ab], j);
        OPMLT: begin
          v = 0;
          for (int k = 0; k < N; k++) v += el(mrf[s][aa], k) * el(mrf[s][(ab + k) % DEPTH], j);
        end
        default: v = el(mrf[s][aa], j);
      endcase
      if (v > MAXE) begin
        ovf = 1'b1;
        v = (s == 1) ? MAXE : v % (MAXE + 1);
      end
      r = r | (16'(v) << (RW - W * (j + 1)));
    end
    return r;
  endfunction

  task automatic load(input int a, input bit [15:0] d);
    ld_en = 1'b1; ld_adrs = 4'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mrf[0][a] = d; mrf[1][a] = d;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, then advance the model in program order.
  task automatic issue(input bit [1:0] op, input int da, input int aa, input int ab, output int stalls);
    bit [15:0] res;
    bit        ovf;
    stalls = 0;
    in_valid = 1'b1; in_op = op; in_da = 4'(da); in_aa = 4'(aa); in_ab = 4'(ab);
    #1;
    while (!rdy[0] && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!rdy[0]) begin
      chk("accept_timeout", 32'(rdy[0]), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    mret++;
    if (op == OPRD) begin
      q.push_back('{due: cyc + 3, adrs: 4'(aa), d0: mrf[0][aa], d1: mrf[1][aa]});
    end else begin
      for (int s = 0; s < 2; s++) begin
        res = m_calc(s, op, aa, ab, ovf);
        mrf[s][da] = res;
        if (ovf) mof[s] = 1'b1;
      end
    end
  endtask

  // RD result scoreboard: strobe exactly three edges after acceptance, idle otherwise.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        chk("rd_valid0", 32'(ov[0]), 32'd1);
        chk("rd_valid1", 32'(ov[1]), 32'd1);
        chk("rd_data0", 32'(od[0]), 32'(mon_e.d0));
        chk("rd_data1", 32'(od[1]), 32'(mon_e.d1));
        chk("rd_adrs0", 32'(oa[0]), 32'(mon_e.adrs));
        chk("rd_adrs1", 32'(oa[1]), 32'(mon_e.adrs));
      end else begin
        chk("idle_valid0", 32'(ov[0]), 32'd0);
        chk("idle_valid1", 32'(ov[1]), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bit [15:0] saved;
    rst = 1'b1; ld_en = 1'b0; in_valid = 1'b0; in_op = '0;
    in_da = '0; in_aa = '0; in_ab = '0; ld_adrs = '0; ld_data = '0;
    mret = 0; mof[0] = 1'b0; mof[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", 32'(ov[s]), 32'd0);
      chk("rst_of", 32'(oof[s]), 32'd0);
      chk("rst_retired", 32'(ret[s]), 32'd0);
      chk("rst_out_data", 32'(od[s]), 32'd0);
      chk("rst_out_adrs", 32'(oa[s]), 32'd0);
      chk("rst_in_ready", 32'(rdy[s]), 32'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic ADD then dependent RD
    load(0, 16'h1234); load(1, 16'h1111);
    issue(OPADD, 2, 0, 1, st);
    issue(OPRD, 0, 2, 0, st);
    chk("rd_after_add_stall", 32'(st), 32'd2);
    drain(4);
    for (int s = 0; s < 2; s++) begin
      chk("add_data", 32'(od[s]), 32'h2345);
      chk("add_adrs", 32'(oa[s]), 32'd2);
      chk("add_of", 32'(oof[s]), 32'd0);
    end

    // Independent instructions back to back, then one true dependency
    issue(OPMV, 10, 0, 0, st);  chk("tp_stall0", 32'(st), 32'd0);
    issue(OPMV, 11, 1, 1, st);  chk("tp_stall1", 32'(st), 32'd0);
    issue(OPADD, 12, 0, 1, st); chk("tp_stall2", 32'(st), 32'd0);
    issue(OPRD, 0, 1, 0, st);   chk("tp_stall3", 32'(st), 32'd0);
    issue(OPRD, 0, 12, 0, st);  chk("dep_stall_one", 32'(st), 32'd1);
    drain(4);

    // MLT against an identity block
    load(4, 16'h1000); load(5, 16'h0100); load(6, 16'h0010); load(7, 16'h0001);
    issue(OPMLT, 8, 0, 4, st);
    issue(OPRD, 0, 8, 0, st);
    drain(4);
    for (int s = 0; s < 2; s++) begin
      chk("mlt_data", 32'(od[s]), 32'h1234);
      chk("mlt_of", 32'(oof[s]), 32'd0);
    end

    // RAW hazard holds the consumer for two cycles
    issue(OPADD, 2, 0, 1, st);
    issue(OPADD, 3, 2, 2, st);
    chk("raw_stall", 32'(st), 32'd2);
    issue(OPRD, 0, 3, 0, st);
    drain(4);
    chk("raw_data", 32'(od[0]), 32'h468A);

    // Host load and commit to the same row on the same edge
    load(0, 16'h5555);
    issue(OPMV, 9, 0, 0, st);
    repeat (2) @(posedge clk);
    #1;
    ld_en = 1'b1; ld_adrs = 4'd9; ld_data = 16'hAAAA;
    @(posedge clk); #1;
    ld_en = 1'b0;
    issue(OPRD, 0, 9, 0, st);
    drain(4);
    chk("ld_vs_commit", 32'(od[0]), 32'h5555);

    // Reset two edges after acceptance discards the ADD
    load(5, 16'h0BAD);
    saved = mrf[0][5];
    issue(OPADD, 5, 0, 1, st);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_ready0", 32'(rdy[0]), 32'd0);
    chk("rst_ready1", 32'(rdy[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mrf[0][5] = saved; mrf[1][5] = saved;
    mret = 0; mof[0] = 1'b0; mof[1] = 1'b0;
    drain(4);
    for (int s = 0; s < 2; s++) begin
      chk("midrst_retired", 32'(ret[s]), 32'd0);
      chk("midrst_of", 32'(oof[s]), 32'd0);
    end
    issue(OPRD, 0, 5, 0, st);
    drain(4);
    chk("midrst_r5", 32'(od[0]), 32'h0BAD);
    chk("midrst_retired_rd", 32'(ret[0]), 32'(mret));

    // Element overflow: wrap vs saturate
    load(0, 16'h000F); load(1, 16'h0001);
    issue(OPADD, 2, 0, 1, st);
    issue(OPRD, 0, 2, 0, st);
    drain(4);
    chk("ovf_wrap_data", 32'(od[0]), 32'h0000);
    chk("ovf_sat_data", 32'(od[1]), 32'h000F);
    chk("ovf_wrap_of", 32'(oof[0]), 32'd1);
    chk("ovf_sat_of", 32'(oof[1]), 32'd1);

    // Randomized instruction stream against the model
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mret = 0; mof[0] = 1'b0; mof[1] = 1'b0;
    for (int r = 0; r < 16; r++) load(r, 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), st);
    end
    drain(5);
    for (int s = 0; s < 2; s++) begin
      chk("rand_retired", 32'(ret[s]), 32'(16'(mret)));
      chk("rand_of", 32'(oof[s]), 32'(mof[s]));
    end
    for (int r = 0; r < 16; r++) issue(OPRD, 0, r, 0, st);
    drain(5);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ipu_pipe.md
IPU_PIPE -- requirements
Module: ipu_pipe

Interface
REQ-001 SHALL have parameter W, default 4, meaning element width in bits.
REQ-002 SHALL have parameter N, default 4, meaning matrix dimension; row width RW = N*W.
REQ-003 SHALL have parameter DEPTH, default 16, meaning register-file rows; AW = clog2(DEPTH).
REQ-004 SHALL have parameter SAT, default 0, meaning 0 = wrap arithmetic, 1 = saturate at 2^W-1.
REQ-005 SHALL have port top_clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port top_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port top_ld_en  in  1  host row-load strobe.
REQ-008 SHALL have port top_ld_adrs  in  AW  host load address.
REQ-009 SHALL have port top_ld_data  in  RW  host load row.
REQ-010 SHALL have port top_in_valid  in  1  instruction offered.
REQ-011 SHALL have port top_in_ready  out  1  instruction accepted when valid&ready.
REQ-012 SHALL have port top_in_op  in  2  opcode: 00 ADD, 01 MLT, 10 MV, 11 RD.
REQ-013 SHALL have ports top_in_DA, top_in_AA, top_in_AB  in  AW each  destination, source A, source B (MLT: base row of B).
REQ-014 SHALL have port top_out_valid  out  1  RD result strobe.
REQ-015 SHALL have port top_out_data  out  RW  RD row data.
REQ-016 SHALL have port top_out_adrs  out  AW  RD row address.
REQ-017 SHALL have port top_OF  out  1  sticky overflow flag.
REQ-018 SHALL have port top_retired  out  16  retired-instruction count, wraps at 2^16.

Function
REQ-019 Element j of a row SHALL occupy bits [RW-1-j*W -: W] (element 0 in MSB).
REQ-020 Pipeline SHALL be three registered stages: accept at edge t, operands registered at t+1, result registered at t+2, commit at t+3.
REQ-021 ADD SHALL compute per element A[j]+B[j]; MV SHALL copy row AA to DA; MLT SHALL compute C[j] = sum over k of A[k]*row(AB+k)[j], AB+k modulo DEPTH.
REQ-022 Overflow SHALL be any element whose true result exceeds 2^W-1; result element SHALL be low W bits (SAT=0) or 2^W-1 (SAT=1); top_OF SHALL set at commit edge and hold until reset.
REQ-023 ADD/MLT/MV SHALL write DA at commit edge; new value readable by instructions accepted at or after t+3.
REQ-024 RD SHALL write nothing; at edge t+3 top_out_valid=1 for one cycle with top_out_data = row AA, top_out_adrs = AA; otherwise top_out_valid=0, data/adrs hold last value.
REQ-025 top_in_ready SHALL be 0 when any read source of the offered instruction (AA; AB for ADD; AB..AB+N-1 for MLT) matches DA of an in-flight non-RD instruction not yet committed; otherwise 1.
REQ-026 top_in_ready SHALL be 0 while top_ld_en=1.
REQ-027 Host load SHALL write at the same edge; if commit targets the same address that edge, commit SHALL win.
REQ-028 top_retired SHALL increment once per commit (including RD).
REQ-029 Back-to-back independent instructions SHALL be accepted every cycle (throughput 1).

Reset
REQ-030 On top_rst at a rising edge: all stage-valid bits, top_out_valid, top_OF, top_retired, top_out_data, top_out_adrs SHALL be 0; top_in_ready SHALL be 0 during reset.
REQ-031 Reset mid-operation SHALL discard all in-flight instructions with no register-file write; register-file contents SHALL be retained.

Structure
REQ-032 Opcode constants and op/row field-slicing helpers SHALL live in shared package ipu_pkg.
REQ-033 Per-element arithmetic (add, multiply-accumulate, overflow, saturation) SHALL be sub-module ipu_lane, instantiated N times.

Verification (N=4, W=4, DEPTH=16)
REQ-034 Load R0=0x1234, R1=0x1111; ADD DA=2 AA=0 AB=1; RD AA=2 -> out_data 0x2345, out_adrs 2, top_OF=0.
REQ-035 R0=0x000F, R1=0x0001, ADD -> R2=0x0000 and top_OF=1 (SAT=0); 0x000F and top_OF=1 (SAT=1).
REQ-036 R4..R7 = 0x1000,0x0100,0x0010,0x0001, R0=0x1234; MLT DA=8 AA=0 AB=4; RD 8 -> 0x1234.
REQ-037 ADD DA=2 AA=0 AB=1 then ADD DA=3 AA=2 AB=2 offered next cycle -> in_ready low 2 cycles, R3=0x468A for R0=0x1234, R1=0x1111.
REQ-038 Accept ADD DA=5, assert top_rst at t+2 -> R5 unchanged, top_retired=0, top_OF=0.
REQ-039 Host load R9=0xAAAA same edge as commit DA=9 value 0x5555 -> R9=0x5555.
